system_io_uart_tx: RTL
======================

// Module: system_io_uart_tx
// PURPOSE
//  Output-side peripheral for the processor top entity. It consumes the 17-bit processor
//  output word (strobe + payload) and buffers bytes in a FIFO. It serialises them as 8N1 UART
//  frames on txd, and returns a 17-bit status word that feeds the processor's 17-bit input.
//  It completes the processor's I/O loop: the processor writes characters, and this block
//  transmits them.
// PARAMETERS
//  FIFO_DEPTH    8    byte entries; power of 2, 2..128
//  CLKS_PER_BIT  434  system1000 cycles per UART bit; >= 2
// PORTS
//  system1000      in   1   clock; all logic on rising edge
//  system1000_rst  in   1   synchronous reset, active high
//  io_out          in   17  processor output word: [16]=strobe, [8]=cmd, [7:0]=data, [15:9] ignored
//  io_in           out  17  status word to processor input (registered)
//  txd             out  1   UART serial output, idle high
// BEHAVIOUR
//  Reset (sampled on clock edge): FIFO emptied, overflow=0, state IDLE, txd=1,
//   io_in=17'h10000. Asserting reset mid-frame aborts the frame: txd=1 on the next edge,
//   and queued bytes are lost.
//  Command decode, only when io_out[16]=1:
//   - cmd=0: push io_out[7:0].
//   - cmd=1: clear the overflow flag; nothing is pushed.
//   - io_out[16]=0: no action. One command per cycle; the strobe is level-sampled, so a
//     strobe held for N cycles gives N pushes.
//  Push acceptance:
//   - Accepted if count<FIFO_DEPTH, or if the transmitter pops in the same cycle (count unchanged).
//   - Otherwise the byte is dropped and the sticky overflow flag is set. Overflow is cleared
//     only by cmd=1 or reset.
//   - A cmd=1 and an overflow cannot coincide.
//  FIFO: circular buffer with rd/wr pointers that wrap at FIFO_DEPTH, plus count of width
//   $clog2(FIFO_DEPTH)+1. First-in, first-out; no reordering.
//  Status io_in (registered; reflects state after the current edge, so 1-cycle latency):
//   - [16] ready = (count != FIFO_DEPTH)
//   - [15] overflow
//   - [14] busy = (state != IDLE) | (count != 0)
//   - [13:8] = 0
//   - [7:0] = count, zero-extended
//  TX FSM (baud counter 0..CLKS_PER_BIT-1, bit index 0..7):
//   - IDLE: txd=1. If count!=0: pop head into shift reg, clear baud counter, go START.
//     A pop occurs only in IDLE.
//   - START: txd=0 for CLKS_PER_BIT cycles, then go DATA with bit index 0.
//   - DATA: txd=shift[0], LSB first, each bit CLKS_PER_BIT cycles; shift right after each bit;
//     after bit 7 go STOP.
//   - STOP: txd=1 for CLKS_PER_BIT cycles, then go IDLE.
//   - Frame = 10*CLKS_PER_BIT cycles. Back-to-back frames are separated by exactly
//     1 IDLE cycle of txd=1.
//  Latency: a push on edge k into an empty FIFO with FSM IDLE makes the FSM pop on edge k+1.
//   txd falls on edge k+2.
//  txd is driven from a register with no glitches. There is no flow control from the line side.
// TESTING (bench overrides CLKS_PER_BIT=4, FIFO_DEPTH=4)
//  1 Reset: hold rst 2 cycles -> io_in=17'h10000, txd=1. Reset with strobe high -> nothing pushed.
//  2 Single byte: push 8'hA5 -> txd low 2 edges later. Line samples 0,1,0,1,0,0,1,0,1,1,
//    4 cycles each (40 cycles). busy drops 1 cycle after STOP ends.
//  3 Burst/full: push 6 bytes 0x41..0x46 on consecutive cycles. The first byte is popped by
//    the FSM on the cycle after its push, which frees a slot, so 5 bytes are accepted and 1
//    overflows (assert the exact accepted/dropped split and count trace against the model).
//    Then overflow=1, ready=0. Line carries the 5 accepted bytes in order, 41 cycles apart.
//  4 Push during pop when full: fill to 4 while idle. Push on the FSM pop cycle -> accepted,
//    count stays 4, overflow stays 0.
//  5 Overflow clear: with overflow=1, drive io_out=17'h10100 -> overflow=0 next cycle, count unchanged.
//  6 Mid-frame reset: assert rst during DATA bit 3 -> txd=1, count=0, state IDLE next cycle.
//    A new push transmits a clean frame.

Source files
------------

// File: rtl/system_io_uart_tx_if.sv
// system_io_uart_tx_if
//   Processor-side connection of the UART transmit peripheral.
//   io_out : 17-bit processor output word ([16]=strobe, [8]=cmd, [7:0]=data)
//   io_in  : 17-bit status word returned to the processor input
//   master : processor side (drives io_out, reads io_in)
//   slave  : peripheral side (reads io_out, drives io_in)
interface system_io_uart_tx_if;
  logic [16:0] io_out;
  logic [16:0] io_in;

  modport master (output io_out, input io_in);
  modport slave  (input io_out, output io_in);
endinterface

// File: rtl/system_io_uart_tx.sv
// system_io_uart_tx
//   Output-side peripheral of the processor. Strobed processor words either push
//   a byte into a small FIFO or clear the sticky overflow flag. The transmitter
//   drains the FIFO and sends each byte as an 8N1 UART frame on txd.
// Ports
//   system1000      : clock, all logic on the rising edge
//   system1000_rst  : synchronous reset, active high
//   bus (slave)     : io_out command word in, io_in registered status word out
//                     status = {ready, overflow, busy, 6'b0, count[7:0]}
//   txd             : registered UART serial output, idle high
module system_io_uart_tx #(
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              system1000,
  input  logic              system1000_rst,
  system_io_uart_tx_if.slave bus,
  output logic              txd
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  tx_state_e     state, state_d;
  logic [BW-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift, shift_d;
  logic          txd_d;
  logic [PW-1:0] wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d;
  logic [CW-1:0] count, count_d;
  logic          overflow, overflow_d;
  logic [16:0]   io_in_d;
  logic [7:0]    mem [FIFO_DEPTH];

  logic strobe, is_clear, push_req, push_ok, pop;
  logic [7:0] count_ext;
  logic unused_io_bits;

  assign unused_io_bits = ^bus.io_out[15:9];

  // Command decode, FIFO bookkeeping, transmitter FSM and next status word.
  // A pop only happens in IDLE, and it is what lets a push into a full FIFO succeed.
  always_comb begin
    strobe     = bus.io_out[16];
    is_clear   = strobe & bus.io_out[8];
    push_req   = strobe & ~bus.io_out[8];
    pop        = (state == IDLE) && (count != '0);
    push_ok    = push_req && ((count != DEPTH_C) || pop);

    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    txd_d      = 1'b1;

    overflow_d = overflow;
    if (is_clear) begin
      overflow_d = 1'b0;
    end else if (push_req && !push_ok) begin
      overflow_d = 1'b1;
    end

    wr_ptr_d = push_ok ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_d = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_d  = count + CW'(push_ok) - CW'(pop);

    // txd is derived from the present state, so the line lags the FSM by one edge
    case (state)
      IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          shift_d    = mem[rd_ptr];
          baud_cnt_d = '0;
          state_d    = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        txd_d = shift[0];
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        txd_d = 1'b1;
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          baud_cnt_d = baud_cnt + BW'(1);
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = IDLE;
      end
    endcase

    count_ext          = '0;
    count_ext[CW-1:0]  = count_d;
    io_in_d = {(count_d != DEPTH_C), overflow_d,
               ((state_d != IDLE) || (count_d != '0)), 6'b0, count_ext};
  end

  // State register; reset aborts any frame in flight and discards queued bytes.
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'd0;
      txd        <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      bus.io_in  <= 17'h10000;
    end else begin
      state      <= state_d;
      baud_cnt   <= baud_cnt_d;
      bit_idx    <= bit_idx_d;
      shift      <= shift_d;
      txd        <= txd_d;
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      count      <= count_d;
      overflow   <= overflow_d;
      bus.io_in  <= io_in_d;
    end
  end

  // FIFO storage; a full FIFO popped in the same cycle writes the slot being read,
  // which is safe because the head is captured into the shift register on this edge.
  always_ff @(posedge system1000) begin
    if (!system1000_rst && push_ok) begin
      mem[wr_ptr] <= bus.io_out[7:0];
    end
  end

endmodule
